// File: rtl/cpu_ad48_fetch.sv
// Instruction fetch stage for the cpu_ad48 core.
// Owns the PC, issues single-cycle-latency reads to instruction memory, buffers
// responses in a small FIFO and presents them to decode over valid/ready.
// A redirect from execute flushes the FIFO and squashes the in-flight response.
// Optional macro CPU_AD48_FETCH_PERF_EN adds saturating fetch/squash counters.

`timescale 1ns/1ps

module cpu_ad48_fetch #(
  parameter int unsigned     XLEN       = 48,
  parameter int unsigned     IM_ADDR_W  = 7,
  parameter int unsigned     FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                 clk,
  input  logic                 resetn,
`ifdef CPU_AD48_FETCH_PERF_EN
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_squashed,
`endif
  output logic                 imem_req,
  output logic [IM_ADDR_W-1:0] imem_addr,
  input  logic [XLEN-1:0]      imem_rdata,
  input  logic                 redir_valid,
  input  logic [XLEN-1:0]      redir_pc,
  input  logic                 halt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_instr,
  output logic [XLEN-1:0]      out_pc
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  pc_q;
  logic             inflight_q;
  logic [XLEN-1:0]  req_pc_q;
  logic [XLEN-1:0]  buf_instr_q [FIFO_DEPTH];
  logic [XLEN-1:0]  buf_pc_q    [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W-1:0] occupancy;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A response arriving during a redirect cycle belongs to the wrong path.
  assign push      = inflight_q & ~redir_valid;
  // Slots already promised: entries left after this cycle's pop plus the pending response.
  assign occupancy = count_q - CNT_W'(pop) + CNT_W'(inflight_q);
  assign issue     = resetn & ~halt & ~redir_valid & (occupancy < CNT_W'(FIFO_DEPTH));

  assign imem_req  = issue;
  assign imem_addr = pc_q[IM_ADDR_W-1:0];
  assign out_instr = out_valid ? buf_instr_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? buf_pc_q[rd_ptr_q]    : '0;

  // PC advance / redirect and in-flight request tracking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
    end else begin
      if (redir_valid) begin
        pc_q <= redir_pc;
      end else if (issue) begin
        pc_q <= pc_q + XLEN'(1);
      end
      inflight_q <= issue;
      if (issue) begin
        req_pc_q <= pc_q;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redir_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage; contents are only observed through count_q, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]    <= req_pc_q;
    end
  end

`ifdef CPU_AD48_FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_squashed_q;
  logic [33:0] squash_inc;
  logic [33:0] squash_sum;

  // Wrong-path work this cycle: squashed response plus entries dropped by the flush.
  always_comb begin
    squash_inc = '0;
    if (redir_valid) begin
      squash_inc = 34'(count_q - CNT_W'(pop)) + 34'(inflight_q);
    end
    squash_sum = {2'b00, perf_squashed_q} + squash_inc;
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_fetched_q  <= '0;
      perf_squashed_q <= '0;
    end else begin
      if (push && (perf_fetched_q != 32'hFFFF_FFFF)) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      perf_squashed_q <= (squash_sum > 34'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : squash_sum[31:0];
    end
  end

  assign perf_fetched  = perf_fetched_q;
  assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_cpu_ad48_fetch.sv
// Self-checking bench for cpu_ad48_fetch: a cycle table for the start-up and
// backpressure sequence, a scoreboard of expected (pc, instr) handshakes, and
// hand-written redirect, halt and asynchronous reset sequences.

`timescale 1ns/1ps

module tb_cpu_ad48_fetch;

  logic        clk;
  logic        resetn;
  logic        imem_req;
  logic [6:0]  imem_addr;
  logic [47:0] imem_rdata;
  logic        redir_valid;
  logic [47:0] redir_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_instr;
  logic [47:0] out_pc;
`ifdef CPU_AD48_FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [47:0] exp_q [$];

  cpu_ad48_fetch dut (
    .clk         (clk),
    .resetn      (resetn),
`ifdef CPU_AD48_FETCH_PERF_EN
    .perf_fetched (perf_fetched),
    .perf_squashed(perf_squashed),
`endif
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .halt        (halt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct, address-derived memory contents.
  function automatic logic [47:0] mem_word(input logic [6:0] a);
    return {8'h11, a, 1'b0, 32'h0F0F_0000 + {25'd0, a}};
  endfunction

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pc", {16'd0, out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        check("sb_pc", {16'd0, out_pc}, {16'd0, e});
        check("sb_instr", {16'd0, out_instr}, {16'd0, mem_word(e[6:0])});
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after reset release: "cycle 0".
  task automatic do_reset();
    resetn      = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    halt        = 1'b0;
    out_ready   = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic finish_test(input string name);
    out_ready = 1'b0;
    cycle();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic        ready;
    logic        exp_valid;
    logic [47:0] exp_pc;
    logic        exp_req;
  } vec_t;

  vec_t vecs [11];

  initial begin
    imem_rdata = '0;
    // Start-up then 5 cycles of backpressure after the first valid.
    vecs[0]  = '{1'b1, 1'b0, 48'd0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 48'd0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 48'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 48'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 48'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 48'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 48'd0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 48'd0, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 48'd1, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 48'd2, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 48'd3, 1'b1};

    // Reset state.
    resetn      = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    halt        = 1'b0;
    out_ready   = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);

    // Straight-line fetch.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(48'(i));
    @(negedge clk);
    check("first_req_addr", 64'(imem_addr), 64'd0);
    repeat (6) cycle();
    finish_test("straight_drain");

    // Table: start-up timing and backpressure.
    do_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back(48'(i));
    for (int i = 0; i < 11; i++) begin
      out_ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
      check($sformatf("tbl%0d_req", i), 64'(imem_req), 64'(vecs[i].exp_req));
      check($sformatf("tbl%0d_pc", i), 64'(out_pc), vecs[i].exp_valid ? 64'(vecs[i].exp_pc) : 64'd0);
      check($sformatf("tbl%0d_instr", i), 64'(out_instr),
            vecs[i].exp_valid ? 64'(mem_word(vecs[i].exp_pc[6:0])) : 64'd0);
      cycle();
    end
    finish_test("table_drain");

    // Redirect to 40 while out_pc=2 is presented (cycle 4).
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(48'd0); exp_q.push_back(48'd1); exp_q.push_back(48'd2);
    exp_q.push_back(48'd40); exp_q.push_back(48'd41); exp_q.push_back(48'd42);
    repeat (4) cycle();
    redir_valid = 1'b1;
    redir_pc    = 48'd40;
    @(negedge clk);
    check("redir_no_issue", 64'(imem_req), 64'd0);
    cycle();
    redir_valid = 1'b0;
    @(negedge clk);
    check("redir_flushed", 64'(out_valid), 64'd0);
    check("redir_new_req", 64'(imem_req), 64'd1);
    check("redir_new_addr", 64'(imem_addr), 64'd40);
`ifdef CPU_AD48_FETCH_PERF_EN
    check("perf_squashed_ge1", 64'(perf_squashed >= 32'd1), 64'd1);
    check("perf_fetched", 64'(perf_fetched), 64'd3);
`endif
    repeat (5) cycle();
    finish_test("redir_drain");

    // Back-to-back redirects; second target carries upper PC bits (aliases to 20).
    do_reset();
    out_ready = 1'b1;
    exp_q.push_back(48'd0); exp_q.push_back(48'd1); exp_q.push_back(48'd2);
    exp_q.push_back(48'h0000_8000_0014); exp_q.push_back(48'h0000_8000_0015);
    repeat (4) cycle();
    redir_valid = 1'b1;
    redir_pc    = 48'd10;
    cycle();
    redir_pc    = 48'h0000_8000_0014;
    @(negedge clk);
    check("b2b_no_issue", 64'(imem_req), 64'd0);
    cycle();
    redir_valid = 1'b0;
    @(negedge clk);
    check("b2b_req_addr", 64'(imem_addr), 64'd20);
    repeat (4) cycle();
    finish_test("b2b_drain");

    // Halt after pc 5 issues; then redirect under halt and resume.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(48'(i));
    repeat (5) cycle();
    @(negedge clk);
    check("halt_pc5_issue", {57'd0, imem_req, imem_addr}, {57'd0, 1'b1, 7'd5});
    cycle();
    halt = 1'b1;
    @(negedge clk);
    check("halt_no_issue", 64'(imem_req), 64'd0);
    repeat (2) cycle();
    begin
      logic busy;
      busy = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        busy = busy | out_valid | imem_req;
        cycle();
      end
      check("halt_idle", 64'(busy), 64'd0);
    end
    check("halt_drained", 64'(exp_q.size()), 64'd0);
    exp_q.push_back(48'd50);
    redir_valid = 1'b1;
    redir_pc    = 48'd50;
    @(negedge clk);
    check("halt_redir_no_issue", 64'(imem_req), 64'd0);
    cycle();
    redir_valid = 1'b0;
    @(negedge clk);
    check("halt_still_idle", 64'(imem_req), 64'd0);
    cycle();
    halt = 1'b0;
    @(negedge clk);
    check("resume_addr", {57'd0, imem_req, imem_addr}, {57'd0, 1'b1, 7'd50});
    repeat (3) cycle();
    finish_test("halt_drain");

    // Asynchronous reset with the FIFO full.
    do_reset();
    repeat (4) cycle();
    @(negedge clk);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_req", 64'(imem_req), 64'd0);
    check("async_rst_pc", 64'(out_pc), 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(48'(i));
    repeat (5) cycle();
    finish_test("async_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
